// File: rtl/subtractor.sv
// Registered unsigned subtractor producing sign-magnitude output: s1 = |a - b|, ctrl = (a < b).
// One-cycle latency; outputs hold their value when no valid operands arrive.
module subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s1,
    output logic             ctrl,
    output logic             out_valid
);

    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] mag;

    logic [WIDTH-1:0] s1_d, s1_q;
    logic             ctrl_d, ctrl_q;
    logic             out_valid_d, out_valid_q;

    // Ripple-borrow chain of full-subtractor cells.
    always_comb begin
        borrow    = '0;
        diff      = '0;
        borrow[0] = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            diff[i]       = a[i] ^ b[i] ^ borrow[i];
            borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
        end
    end

    // A final borrow means the raw difference wrapped; negate it to get b - a.
    always_comb begin
        mag = diff;
        if (borrow[WIDTH]) begin
            mag = ~diff + {{(WIDTH - 1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        s1_d        = s1_q;
        ctrl_d      = ctrl_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            s1_d   = mag;
            ctrl_d = borrow[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            ctrl_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            ctrl_q      <= ctrl_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s1        = s1_q;
    assign ctrl      = ctrl_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_subtractor.sv
// Directed self-checking bench for the registered sign-magnitude subtractor.
// Inputs change on falling edges; outputs are sampled on falling edges or between edges.
module tb_subtractor;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s1;
    logic         ctrl;
    logic         out_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .s1        (s1),
        .ctrl      (ctrl),
        .out_valid (out_valid)
    );

    task automatic drive(input logic v, input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        in_valid = v;
        a        = va;
        b        = vb;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 4'(($urandom % 15) + 1);
        b        = 4'($urandom);
        repeat (2) @(negedge clk);
        total++;
        if ({out_valid, ctrl, s1} !== 6'b0) begin
            bad++;
            $display("FAIL reset_hold: got ov=%b ctrl=%b s1=%b, want ov=0 ctrl=0 s1=0000",
                     out_valid, ctrl, s1);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_positive;
        drive(1'b1, 4'b1010, 4'b0110);
        @(negedge clk);
        total++;
        if ({out_valid, ctrl, s1} !== {1'b1, 1'b0, 4'b0100}) begin
            bad++;
            $display("FAIL positive: got ov=%b ctrl=%b s1=%b, want ov=1 ctrl=0 s1=0100",
                     out_valid, ctrl, s1);
        end
    endtask

    task automatic test_negative;
        logic [W-1:0] va [2] = '{4'b0110, 4'b0000};
        logic [W-1:0] vb [2] = '{4'b1010, 4'b1111};
        logic [W-1:0] vs [2] = '{4'b0100, 4'b1111};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, va[i], vb[i]);
            @(negedge clk);
            total++;
            if ({out_valid, ctrl, s1} !== {1'b1, 1'b1, vs[i]}) begin
                bad++;
                $display("FAIL negative[%0d]: got ov=%b ctrl=%b s1=%b, want ov=1 ctrl=1 s1=%b",
                         i, out_valid, ctrl, s1, vs[i]);
            end
        end
    endtask

    task automatic test_equal_extremes;
        logic [W-1:0] va [3] = '{4'b0111, 4'b1111, 4'b0000};
        logic [W-1:0] vb [3] = '{4'b0111, 4'b0000, 4'b0000};
        logic [W-1:0] vs [3] = '{4'b0000, 4'b1111, 4'b0000};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, va[i], vb[i]);
            @(negedge clk);
            total++;
            if ({out_valid, ctrl, s1} !== {1'b1, 1'b0, vs[i]}) begin
                bad++;
                $display("FAIL equal_extreme[%0d]: got ov=%b ctrl=%b s1=%b, want ov=1 ctrl=0 s1=%b",
                         i, out_valid, ctrl, s1, vs[i]);
            end
        end
    endtask

    // Valid and idle cycles interleaved; idle cycles carry junk operands that must be ignored.
    task automatic test_hold_stream;
        logic         vv [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] va [6] = '{4'b0011, 4'b1111, 4'b0001, 4'b0000, 4'b1000, 4'b1100};
        logic [W-1:0] vb [6] = '{4'b0101, 4'b0000, 4'b1001, 4'b1111, 4'b0001, 4'b0100};
        logic         ec [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] es [6] = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
        for (int i = 0; i < 6; i++) begin
            drive(vv[i], va[i], vb[i]);
            @(negedge clk);
            total++;
            if ({out_valid, ctrl, s1} !== {vv[i], ec[i], es[i]}) begin
                bad++;
                $display("FAIL hold_stream[%0d]: got ov=%b ctrl=%b s1=%b, want ov=%b ctrl=%b s1=%b",
                         i, out_valid, ctrl, s1, vv[i], ec[i], es[i]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset;
        drive(1'b1, 4'b0000, 4'b1111);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, ctrl, s1} !== 6'b0) begin
            bad++;
            $display("FAIL async_reset: got ov=%b ctrl=%b s1=%b, want all zero before edge",
                     out_valid, ctrl, s1);
        end
        @(negedge clk);
        total++;
        if ({out_valid, ctrl, s1} !== 6'b0) begin
            bad++;
            $display("FAIL reset_discard: got ov=%b ctrl=%b s1=%b, want all zero",
                     out_valid, ctrl, s1);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({out_valid, ctrl, s1} !== 6'b0) begin
            bad++;
            $display("FAIL reset_release_idle: got ov=%b ctrl=%b s1=%b, want all zero",
                     out_valid, ctrl, s1);
        end
    endtask

    task automatic test_back_to_back;
        logic         exp_c;
        logic [W-1:0] exp_s;
        for (int k = 0; k <= 256; k++) begin
            @(negedge clk);
            if (k > 0) begin
                int pa = (k - 1) / 16;
                int pb = (k - 1) % 16;
                exp_c = (pa < pb);
                exp_s = exp_c ? 4'(pb - pa) : 4'(pa - pb);
                total++;
                if ({out_valid, ctrl, s1} !== {1'b1, exp_c, exp_s}) begin
                    bad++;
                    $display("FAIL b2b a=%0d b=%0d: got ov=%b ctrl=%b s1=%b, want ov=1 ctrl=%b s1=%b",
                             pa, pb, out_valid, ctrl, s1, exp_c, exp_s);
                end
            end
            if (k < 256) begin
                in_valid = 1'b1;
                a        = 4'(k / 16);
                b        = 4'(k % 16);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_tail: got ov=%b, want ov=0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_positive();
        test_negative();
        test_equal_extremes();
        test_hold_stream();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
